// File: rtl/qa_csr_pkg.sv
// Shared CSR address map, frame register offsets and debug request type for the QA CSR bank.
package qa_csr_pkg;

  localparam logic [13:0] CSR_DSM_BASEL          = 14'h1A00;
  localparam logic [13:0] CSR_DSM_BASEH          = 14'h1A04;
  localparam logic [13:0] CSR_CNTXT_BASEL        = 14'h1A08;
  localparam logic [13:0] CSR_CNTXT_BASEH        = 14'h1A0C;
  localparam logic [13:0] CSR_AFU_EN             = 14'h1A10;
  localparam logic [13:0] CSR_AFU_TRIGGER_DEBUG  = 14'h1A14;
  localparam logic [13:0] CSR_FRAME_BASE_DEF     = 14'h1B00;

  // Word offset of a register inside a channel's 16-byte frame window.
  typedef enum logic [1:0] {
    READ_L  = 2'd0,
    READ_H  = 2'd1,
    WRITE_L = 2'd2,
    WRITE_H = 2'd3
  } frame_reg_e;

  localparam int unsigned AFU_DEBUG_REQ_W = 4;
  typedef logic [AFU_DEBUG_REQ_W-1:0] t_AFU_DEBUG_REQ;

endpackage

// File: rtl/qa_csr_bank_reg64.sv
// 64-bit CSR committed atomically: low half lands in a shadow, high-half write commits both.
module qa_csr_reg64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic        invalidate,
  input  logic [31:0] data,
  output logic [63:0] value,
  output logic        committed,
  output logic        update,
  output logic        seq_err
);

  logic [31:0] shadow;
  logic        pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow    <= '0;
      pending   <= 1'b0;
      value     <= '0;
      committed <= 1'b0;
      update    <= 1'b0;
    end else begin
      update <= wr_hi;
      if (wr_lo) begin
        shadow  <= data;
        pending <= 1'b1;
      end else if (wr_hi) begin
        value     <= {data, shadow};
        pending   <= 1'b0;
        committed <= 1'b1;
      end else if (invalidate) begin
        pending   <= 1'b0;
        committed <= 1'b0;
      end
    end
  end

  // A high write without a fresh low half still commits the retained shadow.
  assign seq_err = wr_hi & ~pending;

endmodule

// File: rtl/qa_csr_bank.sv
// QA AFU CSR write decoder with atomic 64-bit commits and per-channel frame bases.
// Optional error counter built only when QA_CSR_ERR_CNT_EN is defined.
module qa_csr_bank
  import qa_csr_pkg::*;
#(
  parameter int unsigned N_CHANNELS     = 1,
  parameter logic [13:0] CSR_FRAME_BASE = CSR_FRAME_BASE_DEF,
  parameter int unsigned TRIG_HOLD      = 1,
  parameter int unsigned DEBUG_W        = $bits(t_AFU_DEBUG_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_valid,
  input  logic [13:0]              cfg_addr,
  input  logic [31:0]              cfg_data,
  output logic [63:0]              dsm_base,
  output logic                     dsm_base_valid,
  output logic [63:0]              cntxt_base,
  output logic                     cntxt_base_valid,
  output logic                     afu_en,
  output logic [DEBUG_W-1:0]       trigger_debug,
  output logic [N_CHANNELS*64-1:0] read_frame,
  output logic [N_CHANNELS*64-1:0] write_frame,
  output logic [N_CHANNELS-1:0]    frame_valid,
  output logic [N_CHANNELS-1:0]    frame_update,
  output logic [15:0]              seq_err_cnt
);

  logic [13:0]             off;
  logic [2:0]              ch;
  frame_reg_e              freg;
  logic                    fixed_hit;
  logic                    frame_hit;
  logic                    unmapped;
  logic                    afu_wr;
  logic                    afu_fall;
  logic                    trig_wr;
  logic [7:0]              hold_cnt;
  logic [2*N_CHANNELS+1:0] seq_err_vec;
  logic                    dsm_upd;
  logic                    cntxt_upd;

  always_comb begin
    off       = cfg_addr - CSR_FRAME_BASE;
    ch        = off[6:4];
    freg      = frame_reg_e'(off[3:2]);
    fixed_hit = (cfg_addr == CSR_DSM_BASEL)   || (cfg_addr == CSR_DSM_BASEH)   ||
                (cfg_addr == CSR_CNTXT_BASEL) || (cfg_addr == CSR_CNTXT_BASEH) ||
                (cfg_addr == CSR_AFU_EN)      || (cfg_addr == CSR_AFU_TRIGGER_DEBUG);
    // Below-base addresses wrap to a large offset and fall out of the window.
    frame_hit = cfg_valid && !fixed_hit && (cfg_addr >= CSR_FRAME_BASE) &&
                (off < 14'(16 * N_CHANNELS));
    unmapped  = cfg_valid && !fixed_hit && !frame_hit;
    afu_wr    = cfg_valid && (cfg_addr == CSR_AFU_EN);
    afu_fall  = afu_wr && afu_en && !cfg_data[0];
    trig_wr   = cfg_valid && (cfg_addr == CSR_AFU_TRIGGER_DEBUG);
  end

  qa_csr_reg64 u_dsm (
    .clk        (clk),
    .reset      (reset),
    .wr_lo      (cfg_valid && (cfg_addr == CSR_DSM_BASEL)),
    .wr_hi      (cfg_valid && (cfg_addr == CSR_DSM_BASEH)),
    .invalidate (1'b0),
    .data       (cfg_data),
    .value      (dsm_base),
    .committed  (dsm_base_valid),
    .update     (dsm_upd),
    .seq_err    (seq_err_vec[0])
  );

  qa_csr_reg64 u_cntxt (
    .clk        (clk),
    .reset      (reset),
    .wr_lo      (cfg_valid && (cfg_addr == CSR_CNTXT_BASEL)),
    .wr_hi      (cfg_valid && (cfg_addr == CSR_CNTXT_BASEH)),
    .invalidate (1'b0),
    .data       (cfg_data),
    .value      (cntxt_base),
    .committed  (cntxt_base_valid),
    .update     (cntxt_upd),
    .seq_err    (seq_err_vec[1])
  );

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
    logic sel;
    logic rd_com, wr_com, rd_upd, wr_upd;

    assign sel = frame_hit && (ch == 3'(c));

    qa_csr_reg64 u_rd (
      .clk        (clk),
      .reset      (reset),
      .wr_lo      (sel && (freg == READ_L)),
      .wr_hi      (sel && (freg == READ_H)),
      .invalidate (afu_fall),
      .data       (cfg_data),
      .value      (read_frame[64*c +: 64]),
      .committed  (rd_com),
      .update     (rd_upd),
      .seq_err    (seq_err_vec[2+2*c])
    );

    qa_csr_reg64 u_wr (
      .clk        (clk),
      .reset      (reset),
      .wr_lo      (sel && (freg == WRITE_L)),
      .wr_hi      (sel && (freg == WRITE_H)),
      .invalidate (afu_fall),
      .data       (cfg_data),
      .value      (write_frame[64*c +: 64]),
      .committed  (wr_com),
      .update     (wr_upd),
      .seq_err    (seq_err_vec[3+2*c])
    );

    assign frame_valid[c]  = rd_com & wr_com;
    assign frame_update[c] = rd_upd | wr_upd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      afu_en <= 1'b0;
    end else if (afu_wr) begin
      afu_en <= cfg_data[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trigger_debug <= '0;
      hold_cnt      <= '0;
    end else if (trig_wr) begin
      trigger_debug <= cfg_data[DEBUG_W-1:0];
      hold_cnt      <= 8'(TRIG_HOLD - 1);
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 8'd1;
    end else begin
      trigger_debug <= '0;
    end
  end

`ifdef QA_CSR_ERR_CNT_EN
  logic [15:0] err_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (((|seq_err_vec) || unmapped) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

  assign seq_err_cnt = err_cnt;
`else
  logic unused_err_src;
  assign unused_err_src = ^{seq_err_vec, unmapped, dsm_upd, cntxt_upd};
  assign seq_err_cnt    = '0;
`endif

`ifdef QA_CSR_ERR_CNT_EN
  logic unused_upd;
  assign unused_upd = dsm_upd ^ cntxt_upd;
`endif

endmodule

// File: doc/qa_csr_bank.md
Name: qa_csr_bank

Overview:
- Parametrised successor to the QA AFU CSR write decoder.
- Decodes host CSR writes into DSM/context bases, AFU enable, a debug trigger, and N_CHANNELS pairs of read/write frame bases.
- New over the prior generation: atomic 64-bit commits through a low-half shadow, per-channel valid/update flags, a debug trigger held for a programmable number of cycles, and channel invalidation when the AFU is disabled.
- Sits between the QA channel-0 receive path and the QA driver/frame logic.

Parameters:
N_CHANNELS, 1, number of read/write frame-base channel pairs (1..8)
CSR_FRAME_BASE, 14'h1B00, byte address of channel 0 frame registers; channel c occupies CSR_FRAME_BASE+16*c .. +15
TRIG_HOLD, 1, cycles the debug trigger stays asserted after a write (1..255)
DEBUG_W, 4, width of the debug request field

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
cfg_valid  in  1  CSR write strobe, one write per cycle
cfg_addr  in  14  CSR byte address, {header[11:0],2'b0}
cfg_data  in  32  CSR write data
dsm_base  out  64  committed DSM base
dsm_base_valid  out  1  DSM base committed since reset
cntxt_base  out  64  committed context base
cntxt_base_valid  out  1  context base committed since reset
afu_en  out  1  AFU enable
trigger_debug  out  DEBUG_W  debug request, nonzero for TRIG_HOLD cycles
read_frame  out  N_CHANNELS*64  per-channel read frame base, channel c at [64c+63:64c]
write_frame  out  N_CHANNELS*64  per-channel write frame base
frame_valid  out  N_CHANNELS  both frame bases of the channel committed
frame_update  out  N_CHANNELS  one-cycle pulse on any commit in the channel
seq_err_cnt  out  16  sequence/unmapped error count (optional feature)

Behaviour:
- Reset: every output is 0; all shadows, pending flags and the hold counter are 0. Reset takes priority over a same-cycle cfg_valid.
- Latency: every output is registered and reflects a write on the cycle after cfg_valid.
- 64-bit registers (DSM, CNTXT, each READ/WRITE frame): L address writes the 32-bit shadow and sets pending; the output is unchanged.
- H address commits {cfg_data, shadow} to the output, clears pending and sets the per-register committed flag. An H write without pending still commits using the retained shadow and counts as a sequence error.
- dsm_base_valid and cntxt_base_valid set on the H commit, not on the L write.
- frame_valid[c] = read-committed[c] AND write-committed[c].
- frame_update[c] pulses in the cycle after any H commit in channel c.
- CSR_AFU_EN: afu_en <= cfg_data[0]. A 1->0 transition clears all frame committed flags (frame_valid goes to 0) and pending flags; frame base values are retained.
- Trigger: a CSR_AFU_TRIGGER_DEBUG write loads trigger_debug <= cfg_data[DEBUG_W-1:0] and hold counter <= TRIG_HOLD-1.
  - Each later cycle: counter>0 decrements; counter==0 clears trigger_debug.
  - A write during the hold restarts the counter with the new value.
  - Writing value 0 clears immediately.
- Channel address decode: off = addr - CSR_FRAME_BASE; ch = off[6:4]; reg = off[3:2] (0 READ_L, 1 READ_H, 2 WRITE_L, 3 WRITE_H). Addresses with ch >= N_CHANNELS are unmapped.
- Unmapped writes have no effect on any state except the error counter.

Optional Feature:
- QA_CSR_ERR_CNT_EN defined: seq_err_cnt increments on each H-without-pending write and each unmapped write. It saturates at 16'hFFFF and is cleared by reset.
- Not defined: the counter logic is not built and seq_err_cnt is tied to 0.

Decomposition:
- Shared package qa_csr_pkg holds the CSR byte-address constants (DSM_BASEL/H, CNTXT_BASEL/H, AFU_EN, TRIGGER_DEBUG, FRAME_BASE), the frame register offset enum, and t_AFU_DEBUG_REQ.
- One sub-module, qa_csr_reg64, implements the shadow, pending flag, committed flag, commit pulse and seq-error strobe. It is instantiated for DSM, CNTXT and 2*N_CHANNELS frame registers.

Test Plan:
- Reset, then write DSM_BASEL=0x89ABCDEF: dsm_base=0 and valid=0. Then write DSM_BASEH=0x01234567: the next cycle dsm_base=0x0123456789ABCDEF and dsm_base_valid=1.
- N_CHANNELS=4: write ch2 READ L/H and WRITE L/H (0x1B20..0x1B2C) → frame_update[2] pulses after each H commit; frame_valid=4'b0100; read_frame/write_frame slice 2 hold the written values; other slices are 0.
- TRIG_HOLD=3: write trigger 0x5 → trigger_debug=5 for exactly 3 cycles, then 0. Rewrite 0x2 at the 2nd cycle → value 2 is held for 3 further cycles.
- afu_en=1, channel 0 valid; write AFU_EN=0 → frame_valid[0]=0 the next cycle, read_frame[0] unchanged. Recommitting READ_H and WRITE_H restores valid.
- With QA_CSR_ERR_CNT_EN: an H write with no prior L, plus a write to channel 5 when N_CHANNELS=4 → seq_err_cnt=2, no frame output changes. Without the macro, seq_err_cnt stays 0.
- Assert reset mid-sequence (after an L write, during a trigger hold) → all outputs 0 the next cycle. A following H write commits {data, 32'h0} and is counted as a sequence error.
